// File: rtl/i2s_pkg.sv
// Shared constants, types and helpers for the I2S microphone receiver.
// Slot/frame geometry is fixed by the I2S 64-fs stereo frame format.
package i2s_pkg;

  localparam int unsigned SAMPLE_BITS = 24;
  localparam int unsigned SLOT_BITS   = 32;
  localparam int unsigned FRAME_BITS  = 64;

  localparam int unsigned POS_W = $clog2(SLOT_BITS);
  localparam int unsigned BIT_W = $clog2(FRAME_BITS);

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [BIT_W-1:0] bit_cnt_t;

  localparam pos_t MSB_POS = pos_t'(1);
  localparam pos_t LSB_POS = pos_t'(24);

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_e;

  // The upper half of the frame carries the right channel.
  function automatic ch_e slot_ch(input bit_cnt_t b);
    return b[BIT_W-1] ? CH_RIGHT : CH_LEFT;
  endfunction

  function automatic logic is_data_pos(input pos_t p);
    return (p >= MSB_POS) && (p <= LSB_POS);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit clock, word select and frame bit counter generator.
// Exposes the fall event so the receiver samples in lockstep with bit_cnt updates.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int unsigned SCK_HALF = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             sck,
  output logic             ws,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             fall
);

  localparam int unsigned      DIV_W    = $clog2(SCK_HALF);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_HALF - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;
  logic             rise;
  bit_cnt_t         bit_next;

  always_comb begin
    wrap     = (div_cnt == DIV_LAST);
    rise     = wrap & ~sck;
    fall     = wrap & sck;
    bit_next = bit_cnt + BIT_W'(1);
  end

  // ws follows the incoming bit count so ws == bit_cnt[5] for the whole period.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      sck     <= 1'b0;
      ws      <= 1'b0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + DIV_W'(1);
      if (rise) begin
        sck <= 1'b1;
      end else if (fall) begin
        sck <= 1'b0;
      end
      if (fall) begin
        bit_cnt <= bit_next;
        ws      <= bit_next[BIT_W-1];
      end
    end
  end

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for stereo 24-bit MEMS microphones.
// Captures each slot's 24-bit word and strobes it out with its channel tag.
module i2s_mic_rx
  import i2s_pkg::*;
#(
  parameter int unsigned SCK_HALF       = 8,
  parameter int unsigned STARTUP_FRAMES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sd,
  output logic                          sck,
  output logic                          ws,
  output logic                          sample_valid,
  output logic signed [SAMPLE_BITS-1:0] sample,
  output logic                          sample_ch
);

  localparam int unsigned      FC_W        = (STARTUP_FRAMES > 0) ? $clog2(STARTUP_FRAMES + 1) : 1;
  localparam logic [FC_W-1:0]  FRAME_LIMIT = FC_W'(STARTUP_FRAMES);

  logic             fall;
  bit_cnt_t         bit_cnt;
  pos_t             pos;
  logic             sd_m;
  logic             sd_s;
  logic [SAMPLE_BITS-1:0] shreg;
  logic [SAMPLE_BITS-1:0] word_next;
  logic [FC_W-1:0]  frame_cnt;
  logic             startup_done;
  logic             word_done;
  logic             frame_wrap;

  i2s_clkgen #(
    .SCK_HALF(SCK_HALF)
  ) u_clkgen (
    .clk     (clk),
    .rst     (rst),
    .sck     (sck),
    .ws      (ws),
    .bit_cnt (bit_cnt),
    .fall    (fall)
  );

  always_comb begin
    pos          = bit_cnt[POS_W-1:0];
    word_next    = {shreg[SAMPLE_BITS-2:0], sd_s};
    word_done    = fall && (pos == LSB_POS);
    frame_wrap   = fall && (bit_cnt == '1);
    // frame_cnt saturates at the limit, so equality means wake-up is over.
    startup_done = (frame_cnt == FRAME_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sd_m         <= 1'b0;
      sd_s         <= 1'b0;
      shreg        <= '0;
      frame_cnt    <= '0;
      sample_valid <= 1'b0;
      sample       <= '0;
      sample_ch    <= CH_LEFT;
    end else begin
      sd_m         <= sd;
      sd_s         <= sd_m;
      sample_valid <= 1'b0;
      if (fall && is_data_pos(pos)) begin
        shreg <= word_next;
      end
      // The LSB arrives on the same fall event that completes the word.
      if (word_done && startup_done) begin
        sample       <= sample_t'(word_next);
        sample_ch    <= slot_ch(bit_cnt);
        sample_valid <= 1'b1;
      end
      if (frame_wrap && !startup_done) begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Scoreboard bench for i2s_mic_rx: a cycle-timed mic model drives sd,
// expected strobes are queued at stimulus time and checked by a monitor.
module tb_i2s_mic_rx;

  localparam int SH = 4;
  localparam int PER = 2 * SH;

  typedef struct {
    logic [23:0] s;
    logic        ch;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  logic sd = 1'b0;

  logic sck0, ws0, sv0, ch0;
  logic signed [23:0] sample0;
  logic sck1, ws1, sv1, ch1;
  logic signed [23:0] sample1;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic chk_en = 1'b0;

  logic [23:0] words [0:63];
  logic        fills [0:63];
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  i2s_mic_rx #(.SCK_HALF(SH), .STARTUP_FRAMES(0)) dut0 (
    .clk(clk), .rst(rst), .sd(sd), .sck(sck0), .ws(ws0),
    .sample_valid(sv0), .sample(sample0), .sample_ch(ch0)
  );

  i2s_mic_rx #(.SCK_HALF(SH), .STARTUP_FRAMES(3)) dut1 (
    .clk(clk), .rst(rst1), .sd(sd), .sck(sck1), .ws(ws1),
    .sample_valid(sv1), .sample(sample1), .sample_ch(ch1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic mic_bit(input int k);
    int n;
    int p;
    logic [23:0] w;
    n = k / 32;
    p = k % 32;
    if (n >= 64) return 1'b0;
    w = words[n];
    if (p >= 1 && p <= 24) return w[24-p];
    return fills[n];
  endfunction

  // Mic: new bit appears 3 clk after each falling sck (period k starts at cycle k*PER).
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (cyc % PER == 3)) sd = mic_bit(cyc / PER);
    end
  end

  // Monitor: ideal sck/ws every cycle, and every strobe against the queues.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sck", 32'(sck0), 32'((cyc % PER) >= SH));
      check("ws", 32'(ws0), 32'(((cyc / PER) % 64) >= 32));
      if (sv0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL strobe0_unexpected: got sample %0h ch %0d expected no strobe (cyc %0d)", sample0, ch0, cyc);
        end else begin
          e0 = q0.pop_front();
          checks--;
          check("strobe0_data", 32'({ch0, sample0}), 32'({e0.ch, e0.s}));
          check("strobe0_cycle", 32'(cyc), 32'(e0.cyc));
        end
      end
      if (sv1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL strobe1_unexpected: got sample %0h ch %0d expected no strobe (cyc %0d)", sample1, ch1, cyc);
        end else begin
          e1 = q1.pop_front();
          checks--;
          check("strobe1_data", 32'({ch1, sample1}), 32'({e1.ch, e1.s}));
          check("strobe1_cycle", 32'(cyc), 32'(e1.cyc));
        end
      end
    end
  end

  function automatic exp_t mk_exp(input int n);
    exp_t e;
    e.s   = words[n];
    e.ch  = 1'(n % 2);
    e.cyc = ((32 * n + 24) * 2 + 2) * SH;
    return e;
  endfunction

  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_cyc", 32'(cyc), 32'(target));
  endtask

  task automatic hold_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst_at(input int target);
    wait_cyc(target);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_drained(input string name);
    check(name, 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      words[i] = '0;
      fills[i] = 1'b0;
    end

    // Reset state after 5 cycles of rst.
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_sck", 32'(sck0), 32'd0);
    check("rst_ws", 32'(ws0), 32'd0);
    check("rst_valid", 32'(sv0), 32'd0);
    check("rst_sample", 32'(sample0), 32'd0);
    check("rst_ch", 32'(ch0), 32'd0);
    check("rst1_valid", 32'(sv1), 32'd0);

    // Directed slots: extreme words, ones in ignored positions of the right slot.
    words[0] = 24'h800001; fills[0] = 1'b0;
    words[1] = 24'h7FFFFF; fills[1] = 1'b1;
    words[2] = 24'h000000; fills[2] = 1'b0;
    for (int n = 0; n < 3; n++) q0.push_back(mk_exp(n));
    rst = 1'b0;
    wait_cyc(800);
    check_drained("directed_drained");

    // Ten frames of random words.
    hold_reset(2);
    for (int n = 0; n < 20; n++) begin
      words[n] = 24'($urandom());
      fills[n] = 1'($urandom());
      q0.push_back(mk_exp(n));
    end
    rst = 1'b0;
    wait_cyc(20 * 256 + 100);
    check_drained("random_drained");

    // Reset at p=12 of a left slot discards the partial word.
    hold_reset(2);
    words[0] = 24'hABCDEF; fills[0] = 1'b1;
    rst = 1'b0;
    pulse_rst_at(100);
    words[0] = 24'h123456; fills[0] = 1'b0;
    words[1] = 24'h654321; fills[1] = 1'b1;
    q0.push_back(mk_exp(0));
    q0.push_back(mk_exp(1));
    @(negedge clk);
    check("midrst_sck", 32'(sck0), 32'd0);
    check("midrst_ws", 32'(ws0), 32'd0);
    wait_cyc(600);
    check_drained("midrst_drained");

    // Reset coinciding with the p=24 fall event suppresses that strobe.
    hold_reset(2);
    words[0] = 24'h5A5A5A; fills[0] = 1'b0;
    rst = 1'b0;
    pulse_rst_at(199);
    words[0] = 24'h0F0F0F; fills[0] = 1'b1;
    q0.push_back(mk_exp(0));
    @(negedge clk);
    check("rstwin_valid", 32'(sv0), 32'd0);
    check("rstwin_sample", 32'(sample0), 32'd0);
    wait_cyc(300);
    check_drained("rstwin_drained");

    // Startup suppression: dut1 stays silent for frames 0-2.
    hold_reset(2);
    for (int n = 0; n < 10; n++) begin
      words[n] = 24'($urandom());
      fills[n] = 1'($urandom());
      q0.push_back(mk_exp(n));
      if (n >= 6) q1.push_back(mk_exp(n));
    end
    rst  = 1'b0;
    rst1 = 1'b0;
    wait_cyc(10 * 256 + 100);
    check_drained("startup_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
